regfile_write_demux_8x32: RTL and testbench
===========================================

Name: regfile_write_demux_8x32

Overview:
Write-side counterpart of the 8-entry x 32-bit register-file read mux. The block accepts single write requests over a valid/ready handshake and decodes the address to one of 8 word registers, with per-byte enables. It also runs a sequenced bulk-clear operation. All register contents are exposed as one packed array that feeds the read-side 8:1 word muxes directly.

Parameters:
WIDTH, 32, bits per register; must be a multiple of 8.
DEPTH, 8, number of registers; address width AW = $clog2(DEPTH) = 3.
ZERO_REG0, 1, when 1 register 0 is hardwired to zero and writes to it are discarded.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
wr_valid  input  1  write request valid.
wr_ready  output  1  block can accept a write this cycle.
wr_addr  input  AW (3)  target register index.
wr_data  input  WIDTH (32)  write data.
wr_be  input  WIDTH/8 (4)  byte enables; bit b covers data[8b+7:8b].
clr_req  input  1  request a bulk clear; sampled only in IDLE.
regs  output  [DEPTH-1:0][WIDTH-1:0]  packed register contents; entry i is register i.
wr_ack  output  1  one-cycle pulse, the cycle after a write is accepted.
busy  output  1  high while a clear sweep is in progress.
clr_done  output  1  one-cycle pulse, the cycle after the last register is cleared.

Behaviour:
- Reset (rst_n low, asynchronous): all regs = 0, state = IDLE, clear index = 0, wr_ack = 0, busy = 0, clr_done = 0.
- wr_ready = (state == IDLE). It is combinational from state only and never depends on wr_valid or clr_req.
- A write is accepted on a rising edge where wr_valid & wr_ready are both high.
- At the accepting edge, regs[wr_addr] byte b takes wr_data byte b for every b with wr_be[b] = 1. Bytes with wr_be[b] = 0 keep their value. No other register changes.
- A write is visible on regs in the cycle after the accepting edge. There is no internal write-to-read bypass.
- wr_ack = 1 for exactly the one cycle after acceptance. It is also issued for wr_be = 0 and for writes to address 0 when ZERO_REG0 = 1.
- ZERO_REG0 = 1: regs[0] reads 0 at all times, including during and after a clear.
- FSM states:
  - IDLE: accept writes. If clr_req = 1, go to CLEAR with index = 0.
  - CLEAR: at each edge, regs[index] = 0 and index increments. After clearing index DEPTH-1, go to IDLE and pulse clr_done in the following cycle.
- Clear timing: a clear takes exactly DEPTH (8) cycles in CLEAR. busy = 1 and wr_ready = 0 throughout.
- clr_req while in CLEAR is ignored; it is not queued.
- wr_valid held high during CLEAR stalls. It must keep addr/data/be stable, and the write is accepted on the first IDLE edge.
- clr_req and an accepted write at the same IDLE edge: the write is performed and acked, then CLEAR starts next cycle. The sweep therefore zeroes the written register as well.
- Index counter is AW bits. The terminal check is index == DEPTH-1, so there is no reliance on wrap-around.
- Reset asserted mid-clear: the block immediately returns to IDLE with all registers zero and no clr_done pulse.
- All outputs are registered except wr_ready.

Test Plan:
- Reset release, then write addr=3 data=0xDEADBEEF be=4'hF -> next cycle regs[3]=0xDEADBEEF, wr_ack=1 for one cycle, all other regs 0.
- regs[5]=0x11223344, then write addr=5 data=0xAABBCCDD be=4'b0101 -> regs[5]=0x11BB33DD.
- ZERO_REG0=1: write addr=0 data=0xFFFFFFFF be=4'hF -> wr_ack pulses, regs[0] stays 0x00000000.
- Fill all regs with nonzero values, pulse clr_req -> busy=1 and wr_ready=0 for 8 cycles, regs[i] zeroed in order i=0..7, clr_done pulses once, then wr_ready=1.
- Same-edge clr_req + write addr=2 data=0x5 -> wr_ack pulses, regs[2]=5 transiently, then cleared by the sweep. A write held valid during busy is accepted on the first IDLE edge.
- rst_n pulsed low at clear cycle 4 -> all regs 0, busy=0, no clr_done pulse, wr_ready=1 after reset release.

Source files
------------

// File: rtl/regfile_write_demux_8x32.sv
// Write side of the 8x32 register file: handshaked byte-enabled word writes
// plus a one-register-per-cycle bulk-clear sequencer.
module regfile_write_demux_8x32 #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 8,
  parameter bit          ZERO_REG0 = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [$clog2(DEPTH)-1:0]    wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [WIDTH/8-1:0]          wr_be,
  input  logic                        clr_req,
  output logic [DEPTH-1:0][WIDTH-1:0] regs,
  output logic                        wr_ack,
  output logic                        busy,
  output logic                        clr_done
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   NB       = WIDTH / 8;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_next;
  logic          accept;
  logic          sweep;
  logic          sweep_last;

  // Ready depends on state alone so the requester never sees a combinational loop.
  assign wr_ready = (state == IDLE);

  // Next-state and per-cycle strobes.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    accept     = 1'b0;
    sweep      = 1'b0;
    sweep_last = 1'b0;
    case (state)
      IDLE: begin
        accept = wr_valid;
        if (clr_req) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      CLEAR: begin
        sweep = 1'b1;
        if (idx == LAST_IDX) begin
          sweep_last = 1'b1;
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + AW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      wr_ack   <= 1'b0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      wr_ack   <= accept;
      busy     <= (state_next == CLEAR);
      clr_done <= sweep_last;
    end
  end

  // Register array: writes and sweep never coincide since they live in different states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (sweep) begin
        regs[idx] <= '0;
      end
      if (accept) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (wr_be[b]) begin
            regs[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
      if (ZERO_REG0) begin
        regs[0] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_demux_8x32.sv
// Randomized scoreboard bench for regfile_write_demux_8x32: the driver predicts
// register contents per write/clear, a monitor compares on wr_ack/busy/clr_done.
module tb_regfile_write_demux_8x32;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;
  typedef logic [DEPTH-1:0][WIDTH-1:0] snap_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        clr_req;
  snap_t       regs;
  logic        wr_ack;
  logic        busy;
  logic        clr_done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];
  snap_t       ack_q[$];
  snap_t       clr_q[$];
  bit          in_sweep;
  int          run;
  snap_t       pre;

  always #5 clk = ~clk;

  regfile_write_demux_8x32 #(.WIDTH(32), .DEPTH(8), .ZERO_REG0(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .clr_req  (clr_req),
    .regs     (regs),
    .wr_ack   (wr_ack),
    .busy     (busy),
    .clr_done (clr_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic snap_t snap();
    snap_t s;
    for (int i = 0; i < DEPTH; i++) s[i] = model[i];
    return s;
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endfunction

  // Byte-masked merge; register 0 is hardwired to zero.
  function automatic void model_write(input int a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
    if (a != 0) model[a] = (model[a] & ~mask) | (d & mask);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a write (optionally with a same-edge clear) and hold it until accepted.
  task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be, input bit clr);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_addr  = 3'(a);
    wr_data  = d;
    wr_be    = be;
    clr_req  = 1'b0;
    while (!wr_ready && n < 50) begin
      step();
      n++;
    end
    if (!wr_ready) begin
      chk("write_ready_timeout", 32'(wr_ready), 32'h1);
      wr_valid = 1'b0;
      return;
    end
    clr_req = clr;
    model_write(a, d, be);
    ack_q.push_back(snap());
    if (clr) begin
      clr_q.push_back(snap());
      model_zero();
    end
    step();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
  endtask

  task automatic do_clear();
    int n;
    n = 0;
    while (!wr_ready && n < 50) begin
      step();
      n++;
    end
    if (!wr_ready) begin
      chk("clear_ready_timeout", 32'(wr_ready), 32'h1);
      return;
    end
    clr_req = 1'b1;
    clr_q.push_back(snap());
    model_zero();
    step();
    clr_req = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) do_write(i, $urandom() | 32'h1, 4'hF, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the queued predictions.
  initial begin : monitor
    in_sweep = 1'b0;
    run      = 0;
    pre      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) chk($sformatf("reset_reg%0d", i), regs[i], 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_wr_ack", 32'(wr_ack), 32'h0);
        chk("reset_clr_done", 32'(clr_done), 32'h0);
        in_sweep = 1'b0;
        run      = 0;
      end else begin
        chk("reg0_zero", regs[0], 32'h0);
        if (wr_ack) begin
          if (ack_q.size() == 0) begin
            chk("unexpected_wr_ack", 32'(wr_ack), 32'h0);
          end else begin
            snap_t e;
            e = ack_q.pop_front();
            for (int i = 0; i < DEPTH; i++) chk($sformatf("ack_reg%0d", i), regs[i], e[i]);
          end
        end
        if (busy) begin
          if (!in_sweep) begin
            in_sweep = 1'b1;
            run      = 0;
            if (clr_q.size() == 0) begin
              chk("unexpected_busy", 32'(busy), 32'h0);
              pre = '0;
            end else begin
              pre = clr_q.pop_front();
            end
          end
          run++;
          chk("busy_len_bound", 32'(run <= DEPTH), 32'h1);
          for (int j = 0; j < DEPTH; j++)
            chk($sformatf("sweep%0d_reg%0d", run, j), regs[j], (j < run - 1) ? 32'h0 : pre[j]);
        end
        if (clr_done) begin
          if (!in_sweep) begin
            chk("unexpected_clr_done", 32'(clr_done), 32'h0);
          end else begin
            chk("sweep_cycles", run, DEPTH);
            for (int j = 0; j < DEPTH; j++) chk($sformatf("cleared_reg%0d", j), regs[j], 32'h0);
          end
          in_sweep = 1'b0;
          run      = 0;
        end else if (in_sweep && !busy) begin
          chk("missing_clr_done", 32'(clr_done), 32'h1);
          in_sweep = 1'b0;
          run      = 0;
        end
        chk("wr_ready", 32'(wr_ready), in_sweep ? 32'h0 : 32'h1);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver: directed cases from the plan, then randomized traffic.
  initial begin : driver
    int n;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 3'h0;
    wr_data  = 32'h0;
    wr_be    = 4'h0;
    clr_req  = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    do_write(3, 32'hDEADBEEF, 4'hF, 1'b0);
    step();
    do_write(5, 32'h11223344, 4'hF, 1'b0);
    do_write(5, 32'hAABBCCDD, 4'b0101, 1'b0);
    do_write(0, 32'hFFFFFFFF, 4'hF, 1'b0);
    do_write(6, 32'h12345678, 4'h0, 1'b0);
    step();

    fill_all();
    do_clear();
    repeat (3) step();

    fill_all();
    do_write(2, 32'h5, 4'hF, 1'b1);
    do_write(4, 32'hCAFEF00D, 4'hF, 1'b0);
    do_write(7, 32'h0BADF00D, 4'b1010, 1'b0);
    step();

    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 24);
      if (r == 0) do_clear();
      else if (r == 1) do_write($urandom_range(0, 7), $urandom(), 4'($urandom_range(0, 15)), 1'b1);
      else do_write($urandom_range(0, 7), $urandom(), 4'($urandom_range(0, 15)), 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    // Reset in the middle of a sweep.
    fill_all();
    do_clear();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    ack_q.delete();
    clr_q.delete();
    model_zero();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();

    for (int k = 0; k < 20; k++) do_write($urandom_range(1, 7), $urandom(), 4'hF, 1'b0);

    n = 0;
    while ((ack_q.size() != 0 || clr_q.size() != 0 || in_sweep) && n < 40) begin
      step();
      n++;
    end
    repeat (2) step();
    chk("ack_queue_drained", ack_q.size(), 32'h0);
    chk("clr_queue_drained", clr_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
